// File: rtl/ysyx_23060184_ifu.sv
// Instruction fetch unit: issues one read per instruction over an AXI-lite style
// read channel, hands the word to decode, then waits for the retire pulse to pick the next PC.
module ysyx_23060184_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // read address channel
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  // read data channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  // decode handshake
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  // retire / next-PC selection
  input  logic        wb_valid,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  input  logic [31:0] CsrRead,
  output logic        fetch_err
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST  = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam logic [1:0]      RESP_OKAY = 2'b00;

  localparam logic [1:0] SRC_PLUS4  = 2'b00;
  localparam logic [1:0] SRC_TARGET = 2'b01;
  localparam logic [1:0] SRC_ALU    = 2'b10;

  typedef enum logic [2:0] {
    S_AR      = 3'd0,
    S_R       = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_WB = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t          state;
  logic [XLEN-1:0] next_pc_c;

  // Next-PC mux; the ALU path clears bit 0 as JALR requires, all sums wrap mod 2^32.
  always_comb begin
    next_pc_c = pc + PC_STEP;
    case (PCSrc)
      SRC_PLUS4:  next_pc_c = pc + PC_STEP;
      SRC_TARGET: next_pc_c = PCTarget;
      SRC_ALU:    next_pc_c = ALUResult & ~XLEN'(1);
      default:    next_pc_c = CsrRead;
    endcase
  end

  // The fetch address is always the current PC; pc only moves on retire or reset.
  assign araddr = pc;

  // Fetch FSM with registered handshake outputs; reset dominates every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_AR;
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      fetch_err  <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        S_AR: begin
          if (arvalid && arready) begin
            state   <= S_R;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end else begin
            arvalid <= 1'b1;
          end
        end
        S_R: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (rresp == RESP_OKAY) begin
              inst       <= rdata;
              inst_valid <= 1'b1;
              state      <= S_ISSUE;
            end else begin
              fetch_err <= 1'b1;
              state     <= S_ERR;
            end
          end
        end
        S_ISSUE: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= S_WAIT_WB;
          end
        end
        S_WAIT_WB: begin
          if (wb_valid) begin
            pc      <= next_pc_c;
            arvalid <= 1'b1;
            state   <= S_AR;
          end
        end
        S_ERR: begin
          arvalid    <= 1'b0;
          rready     <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: begin
          state      <= S_ERR;
          fetch_err  <= 1'b1;
          arvalid    <= 1'b0;
          rready     <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
// Bench for the fetch unit: directed scenarios plus randomized fetch/retire traffic
// checked against a transaction-level model of the PC and the last fetched word.
module tb_ysyx_23060184_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        wb_valid = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] PCTarget = 32'h0;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] CsrRead = 32'h0;
  logic        fetch_err;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: address of the outstanding/current instruction and last good word
  logic [31:0] exp_pc    = RESET_PC;
  logic [31:0] last_inst = NOP_INST;

  ysyx_23060184_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .pc(pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .wb_valid(wb_valid), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .ALUResult(ALUResult), .CsrRead(CsrRead), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule.
  function automatic logic [31:0] ref_next(input logic [1:0] src, input logic [31:0] cur,
                                           input logic [31:0] tgt, input logic [31:0] alu,
                                           input logic [31:0] csr);
    case (src)
      2'd0:    return cur + 32'd4;
      2'd1:    return tgt;
      2'd2:    return {alu[31:1], 1'b0};
      default: return csr;
    endcase
  endfunction

  task automatic clear_noise();
    rvalid = 1'b0; wb_valid = 1'b0; inst_ready = 1'b0; rresp = 2'b00;
  endtask

  // Reset with conflicting events asserted in the same cycle, then release.
  task automatic do_reset();
    rst = 1'b1; wb_valid = 1'b1; rvalid = 1'b1; rresp = 2'b10; rdata = 32'hBAD0_BAD0;
    tick();
    clear_noise();
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", inst, NOP_INST);
    rst = 1'b0;
    tick();
    exp_pc = RESET_PC;
    last_inst = NOP_INST;
    check("post_rst_arvalid", 32'(arvalid), 32'd1);
    check("post_rst_araddr", araddr, RESET_PC);
  endtask

  // One read transaction from an asserted arvalid up to the response.
  task automatic do_fetch(input int ar_wait, input int r_wait, input logic [1:0] resp,
                          input logic [31:0] data);
    check("ar_valid", 32'(arvalid), 32'd1);
    check("ar_addr", araddr, exp_pc);
    for (int i = 0; i < ar_wait; i++) begin
      arready = 1'b0;
      rvalid = 1'($urandom_range(0, 1)); rdata = $urandom; rresp = 2'($urandom_range(0, 3));
      wb_valid = 1'($urandom_range(0, 1)); inst_ready = 1'($urandom_range(0, 1));
      tick();
      clear_noise();
      check("ar_hold_valid", 32'(arvalid), 32'd1);
      check("ar_hold_addr", araddr, exp_pc);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("r_arvalid", 32'(arvalid), 32'd0);
    check("r_rready", 32'(rready), 32'd1);
    for (int i = 0; i < r_wait; i++) begin
      wb_valid = 1'($urandom_range(0, 1)); inst_ready = 1'($urandom_range(0, 1));
      PCSrc = 2'($urandom_range(0, 3)); PCTarget = $urandom; ALUResult = $urandom; CsrRead = $urandom;
      tick();
      clear_noise();
      check("r_wait_rready", 32'(rready), 32'd1);
      check("r_wait_pc", pc, exp_pc);
      check("r_wait_inst_valid", 32'(inst_valid), 32'd0);
    end
    rvalid = 1'b1; rdata = data; rresp = resp;
    tick();
    clear_noise();
    if (resp == 2'b00) begin
      last_inst = data;
      check("rsp_inst_valid", 32'(inst_valid), 32'd1);
      check("rsp_inst", inst, data);
      check("rsp_pc", pc, exp_pc);
      check("rsp_rready", 32'(rready), 32'd0);
    end else begin
      check("err_flag", 32'(fetch_err), 32'd1);
      check("err_inst", inst, last_inst);
      check("err_inst_valid", 32'(inst_valid), 32'd0);
      check("err_rready", 32'(rready), 32'd0);
    end
  endtask

  // Decode handshake followed by the retire pulse selecting the next PC.
  task automatic issue_retire(input int hold, input int wb_wait, input logic [1:0] src,
                              input logic [31:0] tgt, input logic [31:0] alu,
                              input logic [31:0] csr);
    for (int i = 0; i < hold; i++) begin
      rvalid = 1'($urandom_range(0, 1)); rdata = $urandom; wb_valid = 1'($urandom_range(0, 1));
      tick();
      clear_noise();
      check("iss_valid", 32'(inst_valid), 32'd1);
      check("iss_inst", inst, last_inst);
      check("iss_pc", pc, exp_pc);
      check("iss_arvalid", 32'(arvalid), 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("acc_inst_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < wb_wait; i++) begin
      rvalid = 1'($urandom_range(0, 1)); rdata = $urandom; inst_ready = 1'($urandom_range(0, 1));
      tick();
      clear_noise();
      check("wb_wait_arvalid", 32'(arvalid), 32'd0);
      check("wb_wait_pc", pc, exp_pc);
      check("wb_wait_inst", inst, last_inst);
    end
    PCSrc = src; PCTarget = tgt; ALUResult = alu; CsrRead = csr; wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    exp_pc = ref_next(src, exp_pc, tgt, alu, csr);
    check("wb_arvalid", 32'(arvalid), 32'd1);
    check("wb_araddr", araddr, exp_pc);
  endtask

  initial begin
    logic [1:0] resp;
    do_reset();

    // Zero-wait fetch of the first word at the reset vector.
    do_fetch(0, 0, 2'b00, 32'h0050_0093);
    check("first_inst", inst, 32'h0050_0093);
    check("first_pc", pc, 32'h8000_0000);

    // Decode stalls for 5 cycles, then sequential next PC.
    issue_retire(5, 1, 2'b00, 32'h0, 32'h0, 32'h0);
    check("seq_addr", araddr, 32'h8000_0004);

    do_fetch(0, 0, 2'b00, 32'h0000_0067);
    issue_retire(0, 0, 2'b10, 32'h1111_1111, 32'h8000_0123, 32'h2222_2222);
    check("alu_addr", araddr, 32'h8000_0122);

    do_fetch(1, 1, 2'b00, 32'h0000_006F);
    issue_retire(1, 0, 2'b01, 32'h8000_1000, 32'h3333_3333, 32'h4444_4444);
    check("tgt_addr", araddr, 32'h8000_1000);

    // Retire pulses during R must not move the PC.
    do_fetch(0, 3, 2'b00, 32'h3020_0073);
    check("pc_after_noise", pc, 32'h8000_1000);
    issue_retire(0, 2, 2'b11, 32'h5555_5555, 32'h6666_6666, 32'h8000_0200);
    check("csr_addr", araddr, 32'h8000_0200);

    // PC arithmetic wraps modulo 2^32.
    do_fetch(0, 0, 2'b00, 32'h0000_0013);
    issue_retire(0, 0, 2'b01, 32'hFFFF_FFFC, 32'h0, 32'h0);
    do_fetch(0, 0, 2'b00, 32'h0000_0013);
    issue_retire(0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
    check("wrap_addr", araddr, 32'h0000_0000);

    // Slow address accept, then an error response: ERR is absorbing.
    do_fetch(3, 0, 2'b10, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1; inst_ready = 1'b1; rvalid = 1'b1; arready = 1'b1;
      tick();
      clear_noise();
      arready = 1'b0;
      check("err_hold_arvalid", 32'(arvalid), 32'd0);
      check("err_hold_flag", 32'(fetch_err), 32'd1);
      check("err_hold_inst_valid", 32'(inst_valid), 32'd0);
    end
    do_reset();

    // Reset during R, with a late response the cycle after release.
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("late_in_r", 32'(rready), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; rvalid = 1'b1; rresp = 2'b00; rdata = 32'hCAFE_F00D;
    tick();
    clear_noise();
    check("late_inst", inst, NOP_INST);
    check("late_inst_valid", 32'(inst_valid), 32'd0);
    check("late_arvalid", 32'(arvalid), 32'd1);
    check("late_araddr", araddr, RESET_PC);
    exp_pc = RESET_PC;
    last_inst = NOP_INST;

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      resp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp, $urandom);
      if (resp != 2'b00) begin
        tick();
        check("rnd_err_arvalid", 32'(arvalid), 32'd0);
        do_reset();
      end else begin
        issue_retire(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
